pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 61 ++++++
 rtl/pipe_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the pipeline-facing signals of the hazard/stall controller.
//
//   master : the datapath side. Drives the ID/EX instruction attributes,
//            redirect and cnt_clr. Receives the pipeline-register controls and
//            the performance counters.
//   slave  : the controller (pipe_ctrl). It is the mirror image of master.
//
// Signals (direction as seen by the controller):
//   id_rs1, id_rs2        in   source registers of the ID instruction
//   id_use_rs1/_rs2       in   ID instruction really reads that source
//   ex_rd                 in   destination of the EX instruction
//   ex_mem_read           in   EX instruction is a load
//   ex_md                 in   EX instruction is mul/div (held while in EX)
//   redirect              in   taken branch / jump resolved in EX
//   cnt_clr               in   synchronous clear of both counters
//   pc_write .. md_done   out  pipeline-register controls
//   stall_cnt, flush_cnt  out  saturating performance counters
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);

  logic [ADDR_W-1:0] id_rs1;
  logic [ADDR_W-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_md;
  logic              redirect;
  logic              cnt_clr;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              ex_hold;
  logic              mem_bubble;
  logic              md_go;
  logic              md_done;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_md, redirect, cnt_clr,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
           mem_bubble, md_go, md_done, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_md, redirect, cnt_clr,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
           mem_bubble, md_go, md_done, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Hazard and stall controller for a 5-stage in-order pipeline. It handles:
//   * control redirects (flush IF/ID and bubble ID/EX),
//   * multi-cycle mul/div ops that occupy EX for exactly MD_LAT cycles,
//   * load-use hazards (one-cycle stall with a bubble into EX),
// and keeps two saturating performance counters (stall and flush cycles).
//
// Parameters:
//   ADDR_W  register-address width
//   MD_LAT  total EX cycles of a mul/div op (must be >= 2)
//   CNT_W   performance-counter width
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    pipe_ctrl_if.slave; every pipeline control output is combinational
//          from the current state, the down-counter and the bus inputs
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int ADDR_W = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input logic       clk,
  input logic       reset,
  pipe_ctrl_if.slave bus
);

  // MD_LAT >= 2 means MD_LAT-2 always fits in $clog2(MD_LAT) bits (>= 1 bit).
  localparam int MdCntW = $clog2(MD_LAT);
  localparam logic [MdCntW-1:0] MdCntLoad = MdCntW'(MD_LAT - 2);

  typedef enum logic {
    RUN,
    MD_BUSY
  } state_t;

  state_t            state;
  logic [MdCntW-1:0] mdCnt;

  logic loadUse;
  logic startMd;
  logic flushEvt;

  logic pcWrite;
  logic ifIdWrite;
  logic ifIdFlush;
  logic idExBubble;
  logic exHold;
  logic memBubble;
  logic mdGo;
  logic mdDone;

  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Register 0 is hard-wired zero, so a load into x0 can never feed a consumer.
  assign loadUse = bus.ex_mem_read && (bus.ex_rd != '0) &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is defaulted before any branch, so no
    // path can leave one unassigned and infer a latch.
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    exHold     = 1'b0;
    memBubble  = 1'b0;
    mdGo       = 1'b0;
    mdDone     = 1'b0;
    startMd    = 1'b0;
    flushEvt   = 1'b0;

    if (reset) begin
      // Keep the front end frozen and NOPs flowing until reset is released.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
    end else if (state == MD_BUSY) begin
      // The mul/div owns EX: redirect, ex_md and load-use are not looked at.
      if (mdCnt != '0) begin
        pcWrite   = 1'b0;
        ifIdWrite = 1'b0;
        exHold    = 1'b1;
        memBubble = 1'b1;
      end else begin
        mdDone = 1'b1;
      end
    end else begin
      // RUN: redirect beats mul/div beats load-use.
      if (bus.redirect) begin
        ifIdFlush  = 1'b1;
        idExBubble = 1'b1;
        flushEvt   = 1'b1;
      end else if (bus.ex_md) begin
        mdGo      = 1'b1;
        pcWrite   = 1'b0;
        ifIdWrite = 1'b0;
        exHold    = 1'b1;
        memBubble = 1'b1;
        startMd   = 1'b1;
      end else if (loadUse) begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        idExBubble = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mul/div sequencing. The issue cycle in RUN is EX cycle 1; MD_BUSY then
  // counts MD_LAT-2 down to 0, and the md_cnt==0 cycle is the final one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state <= RUN;
      mdCnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (startMd) begin
            state <= MD_BUSY;
            mdCnt <= MdCntLoad;
          end
        end
        MD_BUSY: begin
          if (mdCnt == '0) begin
            state <= RUN;
          end else begin
            mdCnt <= mdCnt - 1'b1;
          end
        end
        default: begin
          state <= RUN;
          mdCnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters: saturate at all-ones, clear wins over increment.
  // pcWrite is forced low during reset, but the counters are held in reset
  // then, so reset cycles are never counted as stalls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else if (bus.cnt_clr) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pcWrite && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if (flushEvt && (flushCnt != {CNT_W{1'b1}})) begin
        flushCnt <= flushCnt + 1'b1;
      end
    end
  end

  assign bus.pc_write     = pcWrite;
  assign bus.if_id_write  = ifIdWrite;
  assign bus.if_id_flush  = ifIdFlush;
  assign bus.id_ex_bubble = idExBubble;
  assign bus.ex_hold      = exHold;
  assign bus.mem_bubble   = memBubble;
  assign bus.md_go        = mdGo;
  assign bus.md_done      = mdDone;
  assign bus.stall_cnt    = stallCnt;
  assign bus.flush_cnt    = flushCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Two controllers share one stimulus stream: a wide-counter instance and a
// 2-bit-counter instance that saturates quickly. Each cycle the driver applies
// inputs just after the rising edge, works out the expected response from a
// cycle-level model of the pipeline rules and pushes it into a queue; the
// monitor pops it on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int ADDR_W  = 5;
  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_W_S = 2;
  localparam int CAP     = (1 << CNT_W) - 1;
  localparam int CAP_S   = (1 << CNT_W_S) - 1;

  typedef struct {
    bit              rst;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    bit              useRs1;
    bit              useRs2;
    logic [ADDR_W-1:0] exRd;
    bit              memRead;
    bit              exMd;
    bit              redirect;
    bit              cntClr;
  } stim_t;

  // ctl bit order: pc_write, if_id_write, if_id_flush, id_ex_bubble,
  //                ex_hold, mem_bubble, md_go, md_done
  typedef struct {
    logic [7:0] ctl;
    int         stall;
    int         flush;
    int         stallS;
    int         flushS;
  } exp_t;

  logic clk;
  logic rst;

  pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W))   bus ();
  pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W_S)) busS ();

  pipe_ctrl #(.ADDR_W(ADDR_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  pipe_ctrl #(.ADDR_W(ADDR_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W_S)) dutSat (
    .clk   (clk),
    .reset (rst),
    .bus   (busS.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  exp_t sbQ[$];

  // Reference state: how many EX cycles of the current mul/div are still to
  // come (0 = no mul/div in progress), plus the counter values.
  int mLeft = 0;
  int mStall = 0, mFlush = 0, mStallS = 0, mFlushS = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int bump(input int v, input bit clr, input bit inc, input int cap);
    if (clr) return 0;
    if (inc && v < cap) return v + 1;
    return v;
  endfunction

  task automatic driveBus(input stim_t s);
    rst              = s.rst;
    bus.id_rs1       = s.rs1;       busS.id_rs1       = s.rs1;
    bus.id_rs2       = s.rs2;       busS.id_rs2       = s.rs2;
    bus.id_use_rs1   = s.useRs1;    busS.id_use_rs1   = s.useRs1;
    bus.id_use_rs2   = s.useRs2;    busS.id_use_rs2   = s.useRs2;
    bus.ex_rd        = s.exRd;      busS.ex_rd        = s.exRd;
    bus.ex_mem_read  = s.memRead;   busS.ex_mem_read  = s.memRead;
    bus.ex_md        = s.exMd;      busS.ex_md        = s.exMd;
    bus.redirect     = s.redirect;  busS.redirect     = s.redirect;
    bus.cnt_clr      = s.cntClr;    busS.cnt_clr      = s.cntClr;
  endtask

  // One clock cycle: drive, predict, enqueue, then advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    bit   pw, iw, fl, bb, eh, mb, go, dn, lu, flushNow;
    @(posedge clk);
    #1;
    driveBus(s);

    {pw, iw, fl, bb, eh, mb, go, dn} = 8'b1100_0000;
    flushNow = 1'b0;
    if (s.rst) begin
      {pw, iw, fl, bb, eh, mb, go, dn} = 8'b0011_0000;
      mLeft = 0;
      mStall = 0; mFlush = 0; mStallS = 0; mFlushS = 0;
      e.stall = 0; e.flush = 0; e.stallS = 0; e.flushS = 0;
    end else begin
      e.stall = mStall; e.flush = mFlush; e.stallS = mStallS; e.flushS = mFlushS;
      lu = s.memRead && (s.exRd != 0) &&
           ((s.useRs1 && s.rs1 == s.exRd) || (s.useRs2 && s.rs2 == s.exRd));
      if (mLeft > 1) begin
        pw = 0; iw = 0; eh = 1; mb = 1;
        mLeft--;
      end else if (mLeft == 1) begin
        dn = 1;
        mLeft = 0;
      end else if (s.redirect) begin
        fl = 1; bb = 1; flushNow = 1;
      end else if (s.exMd) begin
        go = 1; pw = 0; iw = 0; eh = 1; mb = 1;
        mLeft = MD_LAT - 1;
      end else if (lu) begin
        pw = 0; iw = 0; bb = 1;
      end
      mStall  = bump(mStall,  s.cntClr, !pw,      CAP);
      mFlush  = bump(mFlush,  s.cntClr, flushNow, CAP);
      mStallS = bump(mStallS, s.cntClr, !pw,      CAP_S);
      mFlushS = bump(mFlushS, s.cntClr, flushNow, CAP_S);
    end
    e.ctl = {pw, iw, fl, bb, eh, mb, go, dn};
    sbQ.push_back(e);
  endtask

  // Monitor: compare whatever the DUTs present against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        check("ctl", {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_bubble,
                      bus.ex_hold, bus.mem_bubble, bus.md_go, bus.md_done}, e.ctl);
        check("ctl_sat", {busS.pc_write, busS.if_id_write, busS.if_id_flush, busS.id_ex_bubble,
                          busS.ex_hold, busS.mem_bubble, busS.md_go, busS.md_done}, e.ctl);
        check("stall_cnt",     32'(bus.stall_cnt),  32'(e.stall));
        check("flush_cnt",     32'(bus.flush_cnt),  32'(e.flush));
        check("stall_cnt_sat", 32'(busS.stall_cnt), 32'(e.stallS));
        check("flush_cnt_sat", 32'(busS.flush_cnt), 32'(e.flushS));
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  initial begin
    stim_t s;
    int    drainWait;

    s = idle();
    s.rst = 1'b1;
    driveBus(s);

    // Reset, then a quiet cycle.
    step(s);
    step(s);
    step(idle());

    // Load-use on rs2 for one cycle, then clear.
    s = idle();
    s.memRead = 1; s.exRd = 5; s.rs2 = 5; s.useRs2 = 1;
    step(s);
    step(idle());

    // x0 destination, and a matching but unused source: neither stalls.
    s = idle();
    s.memRead = 1; s.exRd = 0; s.rs1 = 0; s.useRs1 = 1;
    step(s);
    s = idle();
    s.memRead = 1; s.exRd = 7; s.rs1 = 7; s.useRs1 = 0;
    step(s);

    // Mul/div held for its full MD_LAT cycles, then released.
    s = idle();
    s.exMd = 1;
    repeat (MD_LAT) step(s);
    step(idle());

    // Redirect with load-use and mul/div: flush only.
    s = idle();
    s.redirect = 1; s.exMd = 1; s.memRead = 1; s.exRd = 3; s.rs1 = 3; s.useRs1 = 1;
    step(s);
    // Start a mul/div, then redirect while it is busy.
    s = idle();
    s.exMd = 1;
    step(s);
    s.redirect = 1;
    repeat (MD_LAT - 1) step(s);
    step(idle());

    // Back-to-back mul/div.
    s = idle();
    s.exMd = 1;
    repeat (2 * MD_LAT) step(s);
    step(idle());

    // Reset in the second cycle of a mul/div: no md_done afterwards.
    s = idle();
    s.exMd = 1;
    step(s);
    s = idle();
    s.rst = 1;
    step(s);
    repeat (MD_LAT + 1) step(idle());

    // Five stall cycles saturate the 2-bit counter; then clear during a stall.
    s = idle();
    s.memRead = 1; s.exRd = 9; s.rs1 = 9; s.useRs1 = 1;
    repeat (5) step(s);
    s.cntClr = 1;
    step(s);
    step(idle());

    // Randomised traffic; small register range makes hazards common.
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 99) == 0);
      s.rs1      = ADDR_W'($urandom_range(0, 3));
      s.rs2      = ADDR_W'($urandom_range(0, 3));
      s.useRs1   = $urandom_range(0, 1) != 0;
      s.useRs2   = $urandom_range(0, 1) != 0;
      s.exRd     = ADDR_W'($urandom_range(0, 3));
      s.memRead  = $urandom_range(0, 1) != 0;
      s.exMd     = ($urandom_range(0, 4) == 0);
      s.redirect = ($urandom_range(0, 5) == 0);
      s.cntClr   = ($urandom_range(0, 39) == 0);
      step(s);
    end

    // Let the monitor consume the remaining predictions, with a bound.
    drainWait = 0;
    while (sbQ.size() > 0 && drainWait < 10) begin
      @(negedge clk);
      #1;
      drainWait++;
    end
    check("scoreboard_drained", 32'(sbQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
